// File: rtl/rom8x16_if.sv
// Read-request bus for the rom8x16 lookup table: the requester presents
// rd_en/addr, and the ROM answers with dout/dout_valid one clock later.
interface rom8x16_if #(
   parameter int ADDR_W = 3,
   parameter int DATA_W = 16
);
   logic              rd_en;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] dout;
   logic              dout_valid;

   modport master (
      output rd_en,
      output addr,
      input  dout,
      input  dout_valid
   );

   modport slave (
      input  rd_en,
      input  addr,
      output dout,
      output dout_valid
   );
endinterface : rom8x16_if

// File: rtl/rom8x16.sv
// Fixed-content 8x16 lookup table with a registered, one-cycle-latency read.
// Word i holds 16'h1111 * i; addresses at or beyond DEPTH read back as zero.
module rom8x16 #(
   parameter int ADDR_W = 3,
   parameter int DATA_W = 16,
   parameter int DEPTH  = 8
) (
   input  logic       clk,
   input  logic       rst,
   rom8x16_if.slave   bus
);

   logic [DATA_W-1:0] dout_q, dout_d;
   logic              dout_valid_q, dout_valid_d;
   logic [DATA_W-1:0] rom_word;

   // Contents are a pure function of the index, so the table folds into
   // constant decode logic rather than storage.
   function automatic logic [DATA_W-1:0] word_at(input logic [ADDR_W-1:0] idx);
      logic [31:0] full;
      if (int'(idx) >= DEPTH) begin
         return '0;
      end
      full = 32'(idx) * 32'h0000_1111;
      return DATA_W'(full);
   endfunction

   assign rom_word = word_at(bus.addr);

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves a value unassigned and no latch is inferred.
      dout_d       = dout_q;
      dout_valid_d = 1'b0;
      if (bus.rd_en) begin
         dout_d       = rom_word;
         dout_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples the pre-edge values of its inputs.
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
      end
   end

   assign bus.dout       = dout_q;
   assign bus.dout_valid = dout_valid_q;

endmodule : rom8x16

// File: tb/tb_rom8x16.sv
// Self-checking bench for rom8x16: directed reset/sweep/hold/async-reset
// scenarios followed by randomized reads against a behavioural model.
module tb_rom8x16;

   logic clk;
   logic rst;
   int   tests_run;
   int   tests_failed;

   rom8x16_if #(.ADDR_W(3), .DATA_W(16)) bus ();

   rom8x16 #(.ADDR_W(3), .DATA_W(16), .DEPTH(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference contents: word i = 0x1111 * i, zero beyond the populated range.
   function automatic logic [15:0] ref_word(input int a);
      if (a < 0 || a >= 8) return 16'h0000;
      return 16'(a * 'h1111);
   endfunction

   // Present a request, let one rising edge take it, then settle 1 time unit.
   task automatic step(input logic en, input logic [2:0] a);
      bus.rd_en = en;
      bus.addr  = a;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      bus.rd_en = 1'b1;
      bus.addr  = 3'd5;
      #1;
      tests_run++;
      if (bus.dout !== 16'h0000 || bus.dout_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_t0: dout=%h valid=%b, expected 0000/0", bus.dout, bus.dout_valid);
      end
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         #1;
         tests_run++;
         if (bus.dout !== 16'h0000 || bus.dout_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_held[%0d]: dout=%h valid=%b, expected 0000/0",
                     i, bus.dout, bus.dout_valid);
         end
      end
      rst = 1'b0;
      step(1'b1, 3'd5);
      tests_run++;
      if (bus.dout !== 16'h5555 || bus.dout_valid !== 1'b1) begin
         tests_failed++;
         $display("FAIL reset_release: dout=%h valid=%b, expected 5555/1", bus.dout, bus.dout_valid);
      end
   endtask

   task automatic test_sweep();
      for (int a = 0; a < 8; a++) begin
         step(1'b1, 3'(a));
         tests_run++;
         if (bus.dout !== ref_word(a) || bus.dout_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL sweep[%0d]: dout=%h valid=%b, expected %h/1",
                     a, bus.dout, bus.dout_valid, ref_word(a));
         end
      end
   endtask

   task automatic test_hold();
      logic [2:0] toggles [3];
      toggles = '{3'd6, 3'd1, 3'd7};
      step(1'b1, 3'd3);
      tests_run++;
      if (bus.dout !== 16'h3333 || bus.dout_valid !== 1'b1) begin
         tests_failed++;
         $display("FAIL hold_read: dout=%h valid=%b, expected 3333/1", bus.dout, bus.dout_valid);
      end
      for (int i = 0; i < 3; i++) begin
         step(1'b0, toggles[i]);
         // Moving addr between edges must not reach dout.
         bus.addr = 3'(toggles[i] + 3'd1);
         #2;
         tests_run++;
         if (bus.dout !== 16'h3333 || bus.dout_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL hold[%0d]: dout=%h valid=%b, expected 3333/0",
                     i, bus.dout, bus.dout_valid);
         end
      end
   endtask

   task automatic test_async_reset();
      for (int a = 0; a <= 4; a++) begin
         step(1'b1, 3'(a));
      end
      tests_run++;
      if (bus.dout !== 16'h4444 || bus.dout_valid !== 1'b1) begin
         tests_failed++;
         $display("FAIL burst_addr4: dout=%h valid=%b, expected 4444/1", bus.dout, bus.dout_valid);
      end
      #1;
      rst = 1'b1;
      #1;
      tests_run++;
      if (bus.dout !== 16'h0000 || bus.dout_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL async_clear: dout=%h valid=%b, expected 0000/0", bus.dout, bus.dout_valid);
      end
      #1;
      rst = 1'b0;
      step(1'b1, 3'd6);
      tests_run++;
      if (bus.dout !== 16'h6666 || bus.dout_valid !== 1'b1) begin
         tests_failed++;
         $display("FAIL post_reset_read: dout=%h valid=%b, expected 6666/1", bus.dout, bus.dout_valid);
      end
   endtask

   task automatic test_random();
      logic [15:0] exp_dout;
      logic        exp_valid;
      logic        en;
      logic [2:0]  a;
      exp_dout = bus.dout;
      for (int i = 0; i < 200; i++) begin
         en = 1'($urandom_range(0, 1));
         a  = 3'($urandom_range(0, 7));
         step(en, a);
         exp_valid = en;
         if (en) exp_dout = ref_word(int'(a));
         tests_run++;
         if (bus.dout !== exp_dout || bus.dout_valid !== exp_valid) begin
            tests_failed++;
            $display("FAIL random[%0d] en=%b addr=%0d: dout=%h valid=%b, expected %h/%b",
                     i, en, a, bus.dout, bus.dout_valid, exp_dout, exp_valid);
         end
      end
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      test_reset();
      test_sweep();
      test_hold();
      test_async_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule : tb_rom8x16
